hazard_scoreboard: RTL and testbench

//  Sequences the ID stage: tracks in-flight register writes for EX, MEM and WB.

---
 rtl/musa_pipe_pkg.sv | 26 ++
 rtl/sb_slot_match.sv | 23 ++
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/musa_pipe_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package musa_pipe_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    // One in-flight register write tracked between ID/EX and write-back.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } hz_slot_t;

    // One-hot mask of the register a slot will write; r0 never shows as busy.
    function automatic logic [NUM_REGS-1:0] slot_dest_mask(input hz_slot_t s);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (s.valid && (s.dest != '0)) begin
            m[s.dest] = 1'b1;
        end else begin
            m = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/sb_slot_match.sv
// Compares one in-flight slot against the source registers of the ID instruction.
module sb_slot_match
    import musa_pipe_pkg::*;
(
    input  hz_slot_t         slot,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rs,
    input  logic             uses_rt,
    output logic             match
);

    // A slot writing r0 can never create a dependency.
    always_comb begin
        match = 1'b0;
        if (slot.valid && (slot.dest != '0)) begin
            match = (uses_rs && (rs == slot.dest)) || (uses_rt && (rt == slot.dest));
        end else begin
            match = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks pending writes in EX/MEM/WB and stalls decode.
module hazard_scoreboard
    import musa_pipe_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic                id_reg_write,
    input  logic [REG_W-1:0]    id_dest,
    input  logic                id_mem_read,
    input  logic                flush,
    output logic                stall,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                bubble,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [15:0]         stall_cycles
);

    hz_slot_t           slot_q [DEPTH];
    hz_slot_t           slot_d [DEPTH];
    logic [DEPTH-1:0]   match_s;
    logic               hazard_s;
    logic               stall_s;
    logic               issue_s;
    logic [15:0]        cnt_q;
    logic [15:0]        cnt_d;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_match
            sb_slot_match u_match (
                .slot    (slot_q[g]),
                .rs      (id_rs),
                .rt      (id_rt),
                .uses_rs (id_uses_rs),
                .uses_rt (id_uses_rt),
                .match   (match_s[g])
            );
        end
    endgenerate

    // With forwarding only a load still in EX blocks; without it any pending write blocks.
    always_comb begin
        hazard_s = 1'b0;
        if (!id_valid) begin
            hazard_s = 1'b0;
        end else if (FWD_EN != 0) begin
            hazard_s = match_s[0] && slot_q[0].is_load;
        end else begin
            hazard_s = |match_s;
        end
        stall_s = hazard_s && !flush;
        issue_s = id_valid && !stall_s && !flush && id_reg_write && (id_dest != '0);
    end

    // Next slot contents: ID enters slot 0 only when it actually issues; older slots shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = '0;
        end
        if (issue_s) begin
            slot_d[0] = '{valid: 1'b1, dest: id_dest, is_load: id_mem_read};
        end else begin
            slot_d[0] = '0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i-1];
        end
    end

    // Stall-cycle counter saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pending-write mask over every occupied slot.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask = busy_mask | slot_dest_mask(slot_q[i]);
        end
    end

    // Pipeline control outputs follow the ID inputs with no added latency.
    always_comb begin
        stall        = stall_s;
        bubble       = stall_s || flush;
        pc_write     = !stall_s;
        ifid_write   = !stall_s;
        stall_cycles = cnt_q;
    end

    // State update; reset drops every pending write and clears the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: one scoreboard without forwarding and one with, driven by shared stimulus.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = 5'd0;
    logic [4:0]  id_rt = 5'd0;
    logic        id_uses_rs = 1'b0;
    logic        id_uses_rt = 1'b0;
    logic        id_reg_write = 1'b0;
    logic [4:0]  id_dest = 5'd0;
    logic        id_mem_read = 1'b0;
    logic        flush = 1'b0;

    logic        stall_nf, pcw_nf, ifw_nf, bub_nf;
    logic [31:0] mask_nf;
    logic [15:0] cnt_nf;
    logic        stall_fw, pcw_fw, ifw_fw, bub_fw;
    logic [31:0] mask_fw;
    logic [15:0] cnt_fw;

    int tests = 0;
    int fails = 0;
    int pushes = 0;
    int pops = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(0)) u_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_dest(id_dest), .id_mem_read(id_mem_read), .flush(flush),
        .stall(stall_nf), .pc_write(pcw_nf), .ifid_write(ifw_nf), .bubble(bub_nf),
        .busy_mask(mask_nf), .stall_cycles(cnt_nf)
    );

    hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1)) u_fw (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_dest(id_dest), .id_mem_read(id_mem_read), .flush(flush),
        .stall(stall_fw), .pc_write(pcw_fw), .ifid_write(ifw_fw), .bubble(bub_fw),
        .busy_mask(mask_fw), .stall_cycles(cnt_fw)
    );

    // Reference model: a list of writes in flight, each stamped with the cycle it entered EX.
    typedef struct {
        int inst;   // 0 = no forwarding, 1 = forwarding
        int dest;
        bit ld;
        int born;
    } rec_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  bb;
        logic [31:0] mask0;
        logic [31:0] mask1;
        logic [15:0] cnt0;
        logic [15:0] cnt1;
    } exp_t;

    rec_t pend[$];
    exp_t expq[$];
    int   cyc = 0;
    int   cnt_m [2] = '{0, 0};

    task automatic step(input logic r, input logic v, input int rs, input int rt,
                        input logic urs, input logic urt, input logic rw, input int dest,
                        input logic mr, input logic fl);
        rec_t        keep[$];
        exp_t        e;
        logic [1:0]  st;
        logic [31:0] m [2];
        int          age;
        bit          dep;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0];
        id_uses_rs = urs; id_uses_rt = urt; id_reg_write = rw;
        id_dest = dest[4:0]; id_mem_read = mr; flush = fl;
        cyc++;
        keep = {};
        foreach (pend[i]) if (cyc - pend[i].born < DEPTH) keep.push_back(pend[i]);
        pend = keep;
        for (int f = 0; f < 2; f++) begin
            st[f] = 1'b0;
            m[f] = 32'd0;
            foreach (pend[i]) begin
                if (pend[i].inst == f) begin
                    age = cyc - pend[i].born;
                    m[f][pend[i].dest] = 1'b1;
                    dep = (urs && rs == pend[i].dest) || (urt && rt == pend[i].dest);
                    if (dep && (f == 0 || (age == 0 && pend[i].ld))) st[f] = 1'b1;
                end
            end
            st[f] = st[f] & v & ~fl;
        end
        e.st = st;
        e.bb = st | {fl, fl};
        e.mask0 = m[0];
        e.mask1 = m[1];
        e.cnt0 = cnt_m[0][15:0];
        e.cnt1 = cnt_m[1][15:0];
        expq.push_back(e);
        pushes++;
        for (int f = 0; f < 2; f++) begin
            if (r) begin
                keep = {};
                foreach (pend[i]) if (pend[i].inst != f) keep.push_back(pend[i]);
                pend = keep;
                cnt_m[f] = 0;
            end else begin
                if (v && !st[f] && !fl && rw && dest != 0)
                    pend.push_back('{inst: f, dest: dest, ld: mr, born: cyc + 1});
                if (st[f] && cnt_m[f] < 65535) cnt_m[f]++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, pops, act, exp);
        end
    endtask

    // Monitor: the DUTs present a fresh response every cycle; compare it with the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            pops++;
            chk("stall_nf", {31'd0, stall_nf}, {31'd0, e.st[0]});
            chk("bubble_nf", {31'd0, bub_nf}, {31'd0, e.bb[0]});
            chk("pc_write_nf", {31'd0, pcw_nf}, {31'd0, ~e.st[0]});
            chk("ifid_write_nf", {31'd0, ifw_nf}, {31'd0, ~e.st[0]});
            chk("busy_mask_nf", mask_nf, e.mask0);
            chk("stall_cycles_nf", {16'd0, cnt_nf}, {16'd0, e.cnt0});
            chk("stall_fw", {31'd0, stall_fw}, {31'd0, e.st[1]});
            chk("bubble_fw", {31'd0, bub_fw}, {31'd0, e.bb[1]});
            chk("pc_write_fw", {31'd0, pcw_fw}, {31'd0, ~e.st[1]});
            chk("ifid_write_fw", {31'd0, ifw_fw}, {31'd0, ~e.st[1]});
            chk("busy_mask_fw", mask_fw, e.mask1);
            chk("stall_cycles_fw", {16'd0, cnt_fw}, {16'd0, e.cnt1});
        end
    end

    initial begin
        // reset held two cycles
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // lw r8 then add r9,r8,r10 held in ID
        step(0, 1, 0, 0, 1, 0, 1, 8, 1, 0);
        repeat (4) step(0, 1, 8, 10, 1, 1, 1, 9, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // add r3 then sub r4,r3,r5 held in ID
        step(0, 1, 1, 2, 1, 1, 1, 3, 0, 0);
        repeat (4) step(0, 1, 3, 5, 1, 1, 1, 4, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // lw r0 then add r1,r0,r2
        step(0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
        repeat (2) step(0, 1, 0, 2, 1, 1, 1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // flush during a stall: lw r11, dependent stalls, then gets killed
        step(0, 1, 0, 0, 1, 0, 1, 11, 1, 0);
        step(0, 1, 11, 11, 1, 1, 1, 12, 0, 0);
        step(0, 1, 11, 11, 1, 1, 1, 12, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset during the second stall cycle
        step(0, 1, 1, 2, 1, 1, 1, 3, 0, 0);
        step(0, 1, 3, 5, 1, 1, 1, 4, 0, 0);
        step(1, 1, 3, 5, 1, 1, 1, 4, 0, 0);
        repeat (2) step(0, 1, 3, 5, 1, 1, 1, 4, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // random traffic over a small register window to provoke dependencies
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        tests++;
        if (pops != pushes || expq.size() != 0) begin
            fails++;
            $display("FAIL drain responses=%0d expected=%0d", pops, pushes);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
